// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a show-ahead byte FIFO with a valid/ready read port.
// Framing errors and overruns are reported as one-cycle pulses; the offending byte is discarded.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            pop;
    logic            wr_en;

    // Two-flop synchronizer path for the asynchronous serial input.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
    end

    // Receiver FSM: start qualification at mid start bit, LSB-first data sampling, stop check.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                        cnt_d   = FULL_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = FULL_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        push_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so push+pop at full both succeed.
    always_comb begin
        pop       = rd_valid & rd_ready;
        wr_en     = push_q & ((level_q != DEPTH_L) | pop);
        overrun_d = push_q & (level_q == DEPTH_L) & ~pop;
        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d   = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // State registers; synchronizer resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Byte storage; contents are only observable through the valid-gated read port, so no reset.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_valid  = (level_q != '0);
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level     = level_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed frames into uart_rx_buffer, checked every cycle against a
// transaction-level queue model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_uart_rx_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Cycles from the rx falling edge to the edge that makes the byte visible:
    // 2 sync + half bit + 9 full bits (start remainder + 8 data, ending at stop sample) + push + FIFO write.
    localparam int LAND  = 2 + CPB / 2 + 9 * CPB + 2;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] level;
    logic       frame_err;
    logic       overrun;

    uart_rx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_start = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic prev_valid = 1'b0;

    // Model state: bytes held by the buffer, plus scheduled arrivals/framing errors.
    logic [7:0] exp_q[$];
    int         land_cyc[$];
    logic [7:0] land_byte[$];
    int         ferr_cyc[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // Drives one 8N1 frame and tells the model when its outcome becomes visible.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        last_start = cyc;
        if (stop_bit) begin
            land_cyc.push_back(cyc + LAND);
            land_byte.push_back(b);
        end else begin
            ferr_cyc.push_back(cyc + LAND - 1);
        end
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            tick(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!rd_valid && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput({name, "_valid_wait"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic popExpect(input logic [7:0] b, input string name);
        waitValid(name);
        checkOutput(name, 32'(rd_data), 32'(b));
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    // Model update: apply pop (consumer handshake) then any scheduled arrival for this edge.
    always @(posedge HCLK) begin
        logic pop_now;
        cyc = cyc + 1;
        if (HRESET) begin
            exp_q.delete();
            land_cyc.delete();
            land_byte.delete();
            ferr_cyc.delete();
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end else begin
            pop_now = rd_ready && (exp_q.size() != 0);
            if (pop_now) void'(exp_q.pop_front());
            exp_ovr = 1'b0;
            if (land_cyc.size() != 0 && land_cyc[0] == cyc) begin
                if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
                else exp_q.push_back(land_byte[0]);
                void'(land_cyc.pop_front());
                void'(land_byte.pop_front());
            end
            exp_ferr = 1'b0;
            if (ferr_cyc.size() != 0 && ferr_cyc[0] == cyc) begin
                exp_ferr = 1'b1;
                void'(ferr_cyc.pop_front());
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            checkOutput("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
            checkOutput("level", 32'(level), 32'(exp_q.size()));
            if (exp_q.size() != 0) checkOutput("rd_data", 32'(rd_data), 32'(exp_q[0]));
            checkOutput("frame_err", 32'(frame_err), 32'(exp_ferr));
            checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
        end
    end

    // Event counters for pulses and the rd_valid rise time.
    always @(negedge HCLK) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rd_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rd_valid;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f0;
        int o0;
        int lat;

        // Reset values
        HRESET = 1'b1;
        tick(3);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'h00);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        HRESET = 1'b0;
        tick(4);

        $display("[TB] test 1: single byte 0x41");
        applyStimulus(8'h41, 1'b1);
        lat = rise_cyc - last_start;
        checkOutput("t1_latency_in_window", 32'(lat >= 155 && lat <= 157), 32'd1);
        checkOutput("t1_rd_data", 32'(rd_data), 32'h41);
        checkOutput("t1_level", 32'(level), 32'd1);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        checkOutput("t1_level_after_pop", 32'(level), 32'd0);
        checkOutput("t1_valid_after_pop", 32'(rd_valid), 32'd0);

        $display("[TB] test 2: start glitch");
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(12);
        checkOutput("t2_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
        checkOutput("t2_level", 32'(level), 32'd0);
        applyStimulus(8'h5A, 1'b1);
        popExpect(8'h5A, "t2_byte");

        $display("[TB] test 3: framing error");
        f0 = ferr_cnt;
        applyStimulus(8'hC3, 1'b0);
        tick(20);
        checkOutput("t3_frame_err_once", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("t3_level", 32'(level), 32'd0);
        applyStimulus(8'h3C, 1'b1);
        popExpect(8'h3C, "t3_byte");

        $display("[TB] test 4: overrun");
        o0 = ovr_cnt;
        for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1);
        tick(4);
        checkOutput("t4_level_full", 32'(level), 32'd4);
        checkOutput("t4_overrun_once", 32'(ovr_cnt - o0), 32'd1);
        popExpect(8'h01, "t4_drain0");
        popExpect(8'h02, "t4_drain1");
        popExpect(8'h03, "t4_drain2");
        popExpect(8'h04, "t4_drain3");
        checkOutput("t4_level_empty", 32'(level), 32'd0);

        $display("[TB] test 5: push and pop at full");
        for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 1'b1);
        tick(2);
        checkOutput("t5_level_full", 32'(level), 32'd4);
        o0 = ovr_cnt;
        fork
            applyStimulus(8'h06, 1'b1);
            begin
                tick(LAND - 1);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
            end
        join
        tick(2);
        checkOutput("t5_level", 32'(level), 32'd4);
        checkOutput("t5_no_overrun", 32'(ovr_cnt - o0), 32'd0);
        popExpect(8'h02, "t5_drain0");
        popExpect(8'h03, "t5_drain1");
        popExpect(8'h04, "t5_drain2");
        popExpect(8'h06, "t5_drain3");

        $display("[TB] test 6: reset mid-frame");
        applyStimulus(8'h11, 1'b1);
        tick(2);
        checkOutput("t6_level_before", 32'(level), 32'd1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (((8'h77) >> i) & 8'h01) != 8'h00;
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        HRESET = 1'b1;
        tick(1);
        checkOutput("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("t6_rst_level", 32'(level), 32'd0);
        checkOutput("t6_rst_rd_data", 32'(rd_data), 32'h00);
        checkOutput("t6_rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("t6_rst_overrun", 32'(overrun), 32'd0);
        tick(2);
        rx = 1'b1;
        HRESET = 1'b0;
        tick(4);
        applyStimulus(8'h88, 1'b1);
        waitValid("t6_after");
        checkOutput("t6_rd_data", 32'(rd_data), 32'h88);
        checkOutput("t6_level", 32'(level), 32'd1);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
